// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

  // Receiver frame states; encoded in 3 bits.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START_B = 3'd1,
    DATA    = 3'd2,
    STOP_B  = 3'd3,
    CLEANUP = 3'd4
  } rx_state_t;

  // Bit period that matches the transmit controller.
  localparam int unsigned DEFAULT_CLKS_PER_BIT = 868;

  // Payload bits per frame (8N1).
  localparam int unsigned DATA_BITS = 8;

  // Width of the per-bit clock counter; covers periods up to 2^19-1.
  localparam int unsigned CNT_W = 19;

  // Width of the data bit index.
  localparam int unsigned BIT_CNT_W = 3;

  // True for every state that belongs to an in-flight frame.
  function automatic logic rx_state_busy(input rx_state_t s);
    return (s != IDLE);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
// Latency: 2 clk cycles from d to q.
// Backpressure: none; samples every cycle.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops; both come out of reset at RST_VAL so the
  // synchronized value starts in a known, benign level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// 8N1 UART receiver with a one-entry byte buffer and framing/overrun flags.
// Latency: valid_o rises HALF_BIT + 9*CLKS_PER_BIT + 3 clk after the rx_i falling edge.
// Backpressure: valid_o held until ack_i; a good frame arriving while full is dropped and flagged.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int unsigned HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_i,
  input  logic       ack_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  output logic       active_o,
  output logic       frame_err_o,
  output logic       overrun_o
);

  // Terminal counts for the start-bit mid-sample and full bit periods.
  localparam logic [CNT_W-1:0]     HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0]     BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT  = BIT_CNT_W'(DATA_BITS - 1);

  rx_state_t            state;
  logic [CNT_W-1:0]     clk_cnt;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic [DATA_BITS-1:0] shift;

  logic rx_s;
  logic rx_prev;
  logic fall;

  // The line is asynchronous; bring it into the clk domain idling high so
  // reset release never looks like a start edge.
  sync_2ff #(
    .RST_VAL(1'b1)
  ) u_rx_sync (
    .clk(clk),
    .rst(rst),
    .d  (rx_i),
    .q  (rx_s)
  );

  // Previous synchronized level for falling-edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_prev <= 1'b1;
    end else begin
      rx_prev <= rx_s;
    end
  end

  assign fall = rx_prev & ~rx_s;

  // Frame FSM with counters, shift register and all registered outputs.
  // The byte buffer is updated in the same edge as the stop-bit sample, so
  // an ack and a new good byte in one cycle simply replace the old byte.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      clk_cnt     <= '0;
      bit_cnt     <= '0;
      shift       <= '0;
      data_o      <= '0;
      valid_o     <= 1'b0;
      active_o    <= 1'b0;
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;

      // Consumer drains the buffer; ignored while empty.
      if (ack_i && valid_o) begin
        valid_o <= 1'b0;
      end

      case (state)
        IDLE: begin
          clk_cnt <= '0;
          bit_cnt <= '0;
          if (fall) begin
            state    <= START_B;
            active_o <= rx_state_busy(START_B);
          end
        end

        START_B: begin
          if (clk_cnt == HALF_LAST) begin
            clk_cnt <= '0;
            bit_cnt <= '0;
            if (!rx_s) begin
              state <= DATA;
            end else begin
              // Line was high again at mid-start: treat as a glitch.
              state    <= IDLE;
              active_o <= rx_state_busy(IDLE);
            end
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end

        DATA: begin
          if (clk_cnt == BIT_LAST) begin
            clk_cnt        <= '0;
            shift[bit_cnt] <= rx_s;
            if (bit_cnt == LAST_BIT) begin
              bit_cnt <= '0;
              state   <= STOP_B;
            end else begin
              bit_cnt <= bit_cnt + BIT_CNT_W'(1);
            end
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end

        STOP_B: begin
          if (clk_cnt == BIT_LAST) begin
            clk_cnt <= '0;
            state   <= CLEANUP;
            if (rx_s) begin
              if (valid_o && !ack_i) begin
                // Buffer still owned by the consumer: drop the new byte.
                overrun_o <= 1'b1;
              end else begin
                data_o  <= shift;
                valid_o <= 1'b1;
              end
            end else begin
              frame_err_o <= 1'b1;
            end
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end

        CLEANUP: begin
          // One dead cycle; the line must be seen high again before a new
          // start edge counts, which the edge detector guarantees.
          state    <= IDLE;
          active_o <= rx_state_busy(IDLE);
        end

        default: begin
          state    <= IDLE;
          active_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl at the default bit period.
// Latency: n/a.
// Backpressure: ack_i driven by the bench.
module tb_uart_rx_ctrl;

  localparam int CPB  = 868;
  localparam int HALF = CPB / 2;
  localparam int LAT  = HALF + 9 * CPB + 3;
  localparam int FRAME_CYC = 10 * CPB;

  logic       clk;
  logic       rst;
  logic       rx_i;
  logic       ack_i;
  logic [7:0] data_o;
  logic       valid_o;
  logic       active_o;
  logic       frame_err_o;
  logic       overrun_o;

  uart_rx_ctrl #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_i       (rx_i),
    .ack_i      (ack_i),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .active_o   (active_o),
    .frame_err_o(frame_err_o),
    .overrun_o  (overrun_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_rng(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Event monitor: counts pulses, pulse widths, valid edges and active time.
  int   cyc = 0;
  int   ferr_n = 0, ovr_n = 0, rise_n = 0, fall_n = 0, act_n = 0;
  int   ferr_w = 0, ovr_w = 0, ferr_wmax = 0, ovr_wmax = 0;
  int   last_rise = 0;
  logic v_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (frame_err_o) begin ferr_n++; ferr_w++; end else ferr_w = 0;
    if (overrun_o)   begin ovr_n++;  ovr_w++;  end else ovr_w = 0;
    if (ferr_w > ferr_wmax) ferr_wmax = ferr_w;
    if (ovr_w > ovr_wmax)   ovr_wmax  = ovr_w;
    if (valid_o && !v_prev) begin rise_n++; last_rise = cyc; end
    if (!valid_o && v_prev) fall_n++;
    if (active_o) act_n++;
    v_prev = valid_o;
  end

  // Drives one frame (start, 8 data LSB first, stop) for ncyc cycles; optionally
  // raises ack_i for exactly the cycle ending at the stop-bit sample edge.
  task automatic send_frame(input logic [7:0] b, input logic stop, input logic ack_stop,
                            input int ncyc, output int start);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    @(posedge clk); #1;
    start = cyc;
    for (int c = 0; c < ncyc; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      rx_i  = bits[c / CPB];
      ack_i = ack_stop && (c == LAT - 1);
    end
    @(posedge clk); #1;
    rx_i  = 1'b1;
    ack_i = 1'b0;
  endtask

  task automatic pulse_ack();
    @(posedge clk); #1 ack_i = 1'b1;
    @(posedge clk); #1 ack_i = 1'b0;
  endtask

  typedef struct {
    logic [7:0] b;
    logic       stop;
    logic       pre_ack;
    logic       ack_stop;
    logic       post_ack;
    logic [7:0] exp_data;
    logic       exp_valid;
    int         exp_ferr;
    int         exp_ovr;
  } vec_t;

  function automatic vec_t mk(input logic [7:0] b, input logic stop, input logic pre,
                              input logic ackst, input logic post, input logic [7:0] ed,
                              input logic ev, input int ef, input int eo);
    vec_t v;
    v.b = b; v.stop = stop; v.pre_ack = pre; v.ack_stop = ackst; v.post_ack = post;
    v.exp_data = ed; v.exp_valid = ev; v.exp_ferr = ef; v.exp_ovr = eo;
    return v;
  endfunction

  // Reference behaviour of the one-entry buffer for a whole frame.
  function automatic void model_frame(input logic v_in, input logic [7:0] d_in, input vec_t r,
                                      output logic v_out, output logic [7:0] d_out,
                                      output int ferr, output int ovr);
    v_out = r.pre_ack ? 1'b0 : v_in;
    d_out = d_in;
    ferr  = 0;
    ovr   = 0;
    if (!r.stop)                      ferr  = 1;
    else if (v_out && !r.ack_stop)    ovr   = 1;
    else begin d_out = r.b; v_out = 1'b1; end
  endfunction

  vec_t vecs[7];

  initial begin
    #(950_000 * 10);
    errors++;
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int         st, f0, o0, r0, fl0, a0;
    logic       mv;
    logic       rv;
    logic [7:0] rd;
    int         rf, ro;
    vec_t       rnd;

    rst   = 1'b0;
    rx_i  = 1'b1;
    ack_i = 1'b0;

    //             byte  stop pre  ackS post  exp_data ev  ferr ovr
    vecs[0] = mk(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b1, 0, 0);
    vecs[1] = mk(8'h3C, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b0, 1, 0);
    vecs[2] = mk(8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 8'h5A, 1'b1, 0, 0);
    vecs[3] = mk(8'h11, 1'b1, 1'b1, 1'b0, 1'b0, 8'h11, 1'b1, 0, 0);
    vecs[4] = mk(8'h22, 1'b1, 1'b0, 1'b0, 1'b1, 8'h11, 1'b1, 0, 1);
    // Random byte after the buffer was drained; expectation from the model.
    rnd = mk(8'($urandom), 1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 8'h00, 1'b0, 0, 0);
    model_frame(1'b0, 8'h11, rnd, rv, rd, rf, ro);
    rnd.exp_data = rd; rnd.exp_valid = rv; rnd.exp_ferr = rf; rnd.exp_ovr = ro;
    vecs[5] = rnd;
    vecs[6] = mk(8'h22, 1'b1, 1'b0, 1'b1, 1'b1, 8'h22, 1'b1, 0, 0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset data_o",      data_o,      0);
    check("reset valid_o",     valid_o,     0);
    check("reset active_o",    active_o,    0);
    check("reset frame_err_o", frame_err_o, 0);
    check("reset overrun_o",   overrun_o,   0);
    @(posedge clk); #1 rst = 1'b1;
    repeat (20) @(posedge clk);

    mv = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (vecs[i].pre_ack) begin pulse_ack(); mv = 1'b0; end
      repeat ($urandom_range(5, 60)) @(posedge clk);
      f0 = ferr_n; o0 = ovr_n; r0 = rise_n; fl0 = fall_n;
      ferr_wmax = 0; ovr_wmax = 0;
      send_frame(vecs[i].b, vecs[i].stop, vecs[i].ack_stop, FRAME_CYC, st);
      repeat (20) @(posedge clk);
      @(negedge clk);
      check($sformatf("row%0d data_o", i),    data_o,          vecs[i].exp_data);
      check($sformatf("row%0d valid_o", i),   valid_o,         vecs[i].exp_valid);
      check($sformatf("row%0d frame_err", i), ferr_n - f0,     vecs[i].exp_ferr);
      check($sformatf("row%0d overrun", i),   ovr_n - o0,      vecs[i].exp_ovr);
      check($sformatf("row%0d valid falls", i), fall_n - fl0,  0);
      check($sformatf("row%0d active_o", i),  active_o,        0);
      check($sformatf("row%0d valid rises", i), rise_n - r0,   int'(!mv && vecs[i].exp_valid));
      if (vecs[i].exp_ferr != 0) check($sformatf("row%0d ferr width", i), ferr_wmax, 1);
      if (vecs[i].exp_ovr != 0)  check($sformatf("row%0d ovr width", i),  ovr_wmax,  1);
      if (!mv && vecs[i].exp_valid)
        check_rng($sformatf("row%0d latency", i), last_rise - st, LAT - 2, LAT + 2);
      mv = vecs[i].exp_valid;
      if (vecs[i].post_ack) begin
        pulse_ack();
        @(negedge clk);
        check($sformatf("row%0d valid after ack", i), valid_o, 0);
        mv = 1'b0;
      end
    end

    // Short low glitch: only the start-bit half period should be active.
    repeat (30) @(posedge clk);
    f0 = ferr_n; o0 = ovr_n; r0 = rise_n; a0 = act_n;
    @(posedge clk); #1 rx_i = 1'b0;
    repeat (300) @(posedge clk);
    #1 rx_i = 1'b1;
    repeat (1000) @(posedge clk);
    @(negedge clk);
    check_rng("glitch active cycles", act_n - a0, HALF - 2, HALF + 2);
    check("glitch frame_err", ferr_n - f0, 0);
    check("glitch overrun",   ovr_n - o0,  0);
    check("glitch valid rises", rise_n - r0, 0);
    check("glitch active_o",  active_o, 0);

    // Reset in the middle of data bit 4, then a clean 0xFF frame.
    f0 = ferr_n; o0 = ovr_n; r0 = rise_n;
    send_frame(8'h00, 1'b1, 1'b0, 4300, st);
    @(negedge clk);
    check("pre-reset active_o", active_o, 1);
    @(posedge clk); #1 rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("rst%0d data_o", k),    data_o,      0);
      check($sformatf("rst%0d valid_o", k),   valid_o,     0);
      check($sformatf("rst%0d active_o", k),  active_o,    0);
      check($sformatf("rst%0d frame_err", k), frame_err_o, 0);
      check($sformatf("rst%0d overrun", k),   overrun_o,   0);
      @(posedge clk);
    end
    #1 rst = 1'b1;
    repeat (2 * CPB) @(posedge clk);
    @(negedge clk);
    check("abort frame_err", ferr_n - f0, 0);
    check("abort overrun",   ovr_n - o0,  0);
    check("abort valid rises", rise_n - r0, 0);

    f0 = ferr_n; o0 = ovr_n; r0 = rise_n;
    send_frame(8'hFF, 1'b1, 1'b0, FRAME_CYC, st);
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("ff data_o",    data_o,  8'hFF);
    check("ff valid_o",   valid_o, 1);
    check("ff frame_err", ferr_n - f0, 0);
    check("ff overrun",   ovr_n - o0,  0);
    check("ff valid rises", rise_n - r0, 1);
    check_rng("ff latency", last_rise - st, LAT - 2, LAT + 2);
    pulse_ack();
    @(negedge clk);
    check("ff valid after ack", valid_o, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
